// File: rtl/mem_top_pipe.sv
// ---------------------------------------------------------------------------
// mem_top_pipe
//   Single-port word memory with a req/gnt request channel and an
//   rvalid/rready response channel. Reads pass through READ_LATENCY pipeline
//   stages and then a first-word fall-through response FIFO. Requests are
//   granted only while a response slot is free, so read data is never lost
//   under back-pressure. With INIT_ZERO=1 the array is zero-filled after
//   every reset before the first grant.
//
//   Optional feature macro: MEM_WR_ACK_EN
//     defined   - every accepted write consumes a credit and returns an
//                 in-order response carrying rdata=0
//     undefined - writes are fire-and-forget
//
// Ports
//   clk_i      clock, all state on the rising edge
//   rst_i      synchronous active-high reset
//   req/gnt    request handshake; accepted when req && gnt
//   we         1 = write, 0 = read
//   addr       word address
//   wdata      write data
//   wmask      per-byte write enables
//   rvalid     response valid
//   rready     response consumed when rvalid && rready
//   rdata      response data (0 while rvalid is low)
//   init_done  array ready; stays high until the next reset
// ---------------------------------------------------------------------------
module mem_top_pipe #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 10,
   parameter int READ_LATENCY = 1,
   parameter bit INIT_ZERO    = 1'b0
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    req,
   output logic                    gnt,
   input  logic                    we,
   input  logic [ADDR_WIDTH-1:0]   addr,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic [DATA_WIDTH/8-1:0] wmask,
   output logic                    rvalid,
   input  logic                    rready,
   output logic [DATA_WIDTH-1:0]   rdata,
   output logic                    init_done
);

   localparam int NUM_WMASKS = DATA_WIDTH / 8;
   localparam int RSP_DEPTH  = READ_LATENCY + 1;
   localparam int DEPTH      = 2 ** ADDR_WIDTH;
   localparam int CNT_W      = $clog2(RSP_DEPTH + 1);
   localparam int PTR_W      = $clog2(RSP_DEPTH);
   localparam logic [CNT_W-1:0] RSP_FULL = CNT_W'(RSP_DEPTH);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RSP_DEPTH - 1);

`ifdef MEM_WR_ACK_EN
   localparam bit WR_ACK = 1'b1;
`else
   localparam bit WR_ACK = 1'b0;
`endif

   typedef enum logic [1:0] {ST_RST, ST_INIT, ST_RUN} state_e;

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   init_cnt_q, init_cnt_d;

   logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
   logic [DATA_WIDTH-1:0]   data_p_q [READ_LATENCY];
   logic [READ_LATENCY-1:0] vld_p_q;
   logic [DATA_WIDTH-1:0]   fifo_q [RSP_DEPTH];
   logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]        fifo_cnt_q, out_cnt_q;

   logic accept, wr_acc, credit;
   logic out_vld, fifo_empty, pop, push, fifo_pop;
   logic [DATA_WIDTH-1:0] out_data;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      state_d    = state_q;
      init_cnt_d = '0;
      case (state_q)
         ST_RST:  state_d = INIT_ZERO ? ST_INIT : ST_RUN;
         ST_INIT: begin
            init_cnt_d = init_cnt_q + 1'b1;
            if (init_cnt_q == '1) state_d = ST_RUN;
         end
         default: state_d = state_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_RST;
         init_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
      end
   end

   // outstanding counts pipeline entries plus FIFO entries, so a grant is
   // only given when a FIFO slot is guaranteed for the eventual response
   assign gnt       = (state_q == ST_RUN) && (out_cnt_q < RSP_FULL);
   assign init_done = (state_q == ST_RUN);
   assign accept    = req && gnt;
   assign wr_acc    = accept && we;
   assign credit    = accept && (!we || WR_ACK);

   // ---- stage p0: array access (write commit / read capture) ----
   always_ff @(posedge clk_i) begin
      if (state_q == ST_INIT) begin
         mem_q[init_cnt_q] <= '0;
      end else if (wr_acc) begin
         for (int i = 0; i < NUM_WMASKS; i++) begin
            if (wmask[i]) mem_q[addr][i*8 +: 8] <= wdata[i*8 +: 8];
         end
      end
   end

   // ---- stages p1..pN: latency pipeline ----
   always_ff @(posedge clk_i) begin
      data_p_q[0] <= we ? '0 : mem_q[addr];
      for (int i = 1; i < READ_LATENCY; i++) data_p_q[i] <= data_p_q[i-1];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vld_p_q <= '0;
      end else begin
         vld_p_q[0] <= credit;
         for (int i = 1; i < READ_LATENCY; i++) vld_p_q[i] <= vld_p_q[i-1];
      end
   end

   // ---- response FIFO (fall-through, pipeline output bypasses when empty) ----
   assign out_vld    = vld_p_q[READ_LATENCY-1];
   assign out_data   = data_p_q[READ_LATENCY-1];
   assign fifo_empty = (fifo_cnt_q == '0);
   assign rvalid     = !fifo_empty || out_vld;
   assign rdata      = !fifo_empty ? fifo_q[rd_ptr_q] : (out_vld ? out_data : '0);
   assign pop        = rvalid && rready;
   // a pipeline word consumed directly through the bypass is never stored
   assign push       = out_vld && !(fifo_empty && rready);
   assign fifo_pop   = pop && !fifo_empty;

   always_ff @(posedge clk_i) begin
      if (push) fifo_q[wr_ptr_q] <= out_data;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fifo_cnt_q <= '0;
         out_cnt_q  <= '0;
      end else begin
         if (push)     wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (fifo_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
         fifo_cnt_q <= fifo_cnt_q + CNT_W'(push) - CNT_W'(fifo_pop);
         out_cnt_q  <= out_cnt_q + CNT_W'(credit) - CNT_W'(pop);
      end
   end

endmodule

// File: tb/tb_mem_top_pipe.sv
module tb_mem_top_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [31:0] mdl [16];
   logic [31:0] exp_q [$];

   // main DUT: READ_LATENCY=2, no init
   logic rst = 1'b1, req = 1'b0, we = 1'b0, rready = 1'b0;
   logic [3:0] addr = '0, wmask = '0;
   logic [31:0] wdata = '0;
   logic gnt, rvalid, init_done;
   logic [31:0] rdata;

   mem_top_pipe #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(2), .INIT_ZERO(1'b0)) u_dut (
      .clk_i(clk), .rst_i(rst), .req(req), .gnt(gnt), .we(we), .addr(addr),
      .wdata(wdata), .wmask(wmask), .rvalid(rvalid), .rready(rready),
      .rdata(rdata), .init_done(init_done));

   // zero-fill DUT
   logic z_rst = 1'b1, z_req = 1'b0, z_we = 1'b0, z_rready = 1'b1;
   logic [3:0] z_addr = '0;
   logic [31:0] z_wdata = '0;
   logic z_gnt, z_rvalid, z_done;
   logic [31:0] z_rdata;

   mem_top_pipe #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(1), .INIT_ZERO(1'b1)) u_zdut (
      .clk_i(clk), .rst_i(z_rst), .req(z_req), .gnt(z_gnt), .we(z_we), .addr(z_addr),
      .wdata(z_wdata), .wmask(4'hF), .rvalid(z_rvalid), .rready(z_rready),
      .rdata(z_rdata), .init_done(z_done));

   // latency sweep: READ_LATENCY = g+1, shared stimulus, always ready
   logic s_rst = 1'b1, s_req = 1'b0, s_we = 1'b0;
   logic [3:0] s_addr = '0;
   logic [31:0] s_wdata = '0;
   logic s_gnt [4];
   logic s_rvalid [4];
   logic s_done [4];
   logic [31:0] s_rdata [4];

   for (genvar g = 0; g < 4; g++) begin : g_sweep
      mem_top_pipe #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(g + 1), .INIT_ZERO(1'b0)) u_sdut (
         .clk_i(clk), .rst_i(s_rst), .req(s_req), .gnt(s_gnt[g]), .we(s_we), .addr(s_addr),
         .wdata(s_wdata), .wmask(4'hF), .rvalid(s_rvalid[g]), .rready(1'b1),
         .rdata(s_rdata[g]), .init_done(s_done[g]));
   end

   // Drive one request on the main DUT (called at a negedge); the expected
   // response, if any, is pushed to the scoreboard at the accept.
   task automatic issue(input logic w, input logic [3:0] a, input logic [31:0] d, input logic [3:0] m);
      int n = 0;
      req = 1'b1; we = w; addr = a; wdata = d; wmask = m;
      while (gnt !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      if (gnt !== 1'b1) begin
         checks++; errors++;
         $display("FAIL issue_gnt_timeout addr=%0d gnt=%b required=1", a, gnt);
      end else if (w) begin
         for (int b = 0; b < 4; b++) if (m[b]) mdl[a][b*8 +: 8] = d[b*8 +: 8];
`ifdef MEM_WR_ACK_EN
         exp_q.push_back(32'h0);
`endif
      end else begin
         exp_q.push_back(mdl[a]);
      end
      @(negedge clk);
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clk);
      checks += 4;
      if (gnt !== 1'b0)       begin errors++; $display("FAIL rst_gnt got=%b required=0", gnt); end
      if (rvalid !== 1'b0)    begin errors++; $display("FAIL rst_rvalid got=%b required=0", rvalid); end
      if (rdata !== 32'h0)    begin errors++; $display("FAIL rst_rdata got=%h required=0", rdata); end
      if (init_done !== 1'b0) begin errors++; $display("FAIL rst_init_done got=%b required=0", init_done); end
      rst = 1'b0; s_rst = 1'b0;
      @(negedge clk);
      checks += 2;
      if (init_done !== 1'b1) begin errors++; $display("FAIL run_init_done got=%b required=1", init_done); end
      if (gnt !== 1'b1)       begin errors++; $display("FAIL run_gnt got=%b required=1", gnt); end
   endtask

   task automatic test_fill;
      int n;
      logic [31:0] e;
      for (int a = 0; a < 16; a++) begin
         issue(1'b1, 4'(a), 32'hC0DE_0000 + 32'(a), 4'hF);
         req = 1'b0;
         rready = 1'b1; n = 0;
         while (exp_q.size() != 0 && n < 40) begin
            if (rvalid === 1'b1) begin
               e = exp_q.pop_front(); checks++;
               if (rdata !== e) begin errors++; $display("FAIL fill_ack got=%h required=%h", rdata, e); end
            end
            @(negedge clk); n++;
         end
         rready = 1'b0;
      end
   endtask

   task automatic test_fwd;
      int n;
      logic [31:0] e;
      issue(1'b1, 4'd3, 32'h1234_5678, 4'hF);
      issue(1'b0, 4'd3, 32'h0, 4'h0);
      req = 1'b0;
      rready = 1'b1; n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         if (rvalid === 1'b1) begin
            e = exp_q.pop_front(); checks++;
            if (rdata !== e) begin errors++; $display("FAIL fwd_rdata got=%h required=%h", rdata, e); end
         end
         @(negedge clk); n++;
      end
      checks++;
      if (exp_q.size() != 0 || rvalid !== 1'b0) begin
         errors++; $display("FAIL fwd_drain left=%0d rvalid=%b required=0/0", exp_q.size(), rvalid);
         exp_q.delete();
      end
      rready = 1'b0;
   endtask

   task automatic test_wmask_zero;
      int n;
      logic [31:0] e;
      issue(1'b1, 4'd5, 32'hDEAD_BEEF, 4'h0);
      issue(1'b0, 4'd5, 32'h0, 4'h0);
      req = 1'b0;
      rready = 1'b1; n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         if (rvalid === 1'b1) begin
            e = exp_q.pop_front(); checks++;
            if (rdata !== e) begin errors++; $display("FAIL wmask0_rdata got=%h required=%h", rdata, e); end
         end
         @(negedge clk); n++;
      end
      rready = 1'b0;
   endtask

   task automatic test_byte_mask;
      int n;
      logic [31:0] e;
      issue(1'b1, 4'd7, 32'hFFFF_FFFF, 4'hF);
      issue(1'b1, 4'd7, 32'h0000_0000, 4'b0101);
      issue(1'b0, 4'd7, 32'h0, 4'h0);
      req = 1'b0;
      rready = 1'b1; n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         if (rvalid === 1'b1) begin
            e = exp_q.pop_front(); checks++;
            if (rdata !== e) begin errors++; $display("FAIL bytemask_rdata got=%h required=%h", rdata, e); end
         end
         @(negedge clk); n++;
      end
      checks++;
      if (mdl[7] !== 32'hFF00_FF00) begin errors++; $display("FAIL bytemask_model got=%h required=ff00ff00", mdl[7]); end
      rready = 1'b0;
   endtask

`ifdef MEM_WR_ACK_EN
   task automatic test_wr_ack;
      int n;
      logic [31:0] e;
      issue(1'b1, 4'd9, 32'hAAAA_5555, 4'hF);
      issue(1'b0, 4'd9, 32'h0, 4'h0);
      issue(1'b1, 4'd10, 32'h5555_AAAA, 4'hF);
      req = 1'b0;
      rready = 1'b1; n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         if (rvalid === 1'b1) begin
            e = exp_q.pop_front(); checks++;
            if (rdata !== e) begin errors++; $display("FAIL wrack_rdata got=%h required=%h", rdata, e); end
         end
         @(negedge clk); n++;
      end
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL wrack_count left=%0d required=0", exp_q.size()); exp_q.delete(); end
      rready = 1'b0;
   endtask
`else
   task automatic test_write_no_rsp;
      rready = 1'b1;
      issue(1'b1, 4'd9, 32'hAAAA_5555, 4'hF);
      req = 1'b0;
      for (int c = 0; c < 5; c++) begin
         checks++;
         if (rvalid !== 1'b0) begin errors++; $display("FAIL write_rsp rvalid=%b required=0", rvalid); end
         @(negedge clk);
      end
      rready = 1'b0;
   endtask
`endif

   task automatic test_back_to_back;
      int k = 0;
      logic [31:0] r0, e;
      rready = 1'b0;
      for (int c = 0; c < 8; c++) begin
         if (k < 4) begin req = 1'b1; we = 1'b0; addr = 4'(k + 1); end else req = 1'b0;
         if (req && gnt) begin exp_q.push_back(mdl[addr]); k++; end
         @(negedge clk);
      end
      req = 1'b0;
      checks += 3;
      if (k != 3)        begin errors++; $display("FAIL bp_accepts got=%0d required=3", k); end
      if (gnt !== 1'b0)  begin errors++; $display("FAIL bp_gnt got=%b required=0", gnt); end
      if (rvalid !== 1'b1) begin errors++; $display("FAIL bp_rvalid got=%b required=1", rvalid); end
      r0 = rdata;
      repeat (3) @(negedge clk);
      checks++;
      if (rdata !== r0 || exp_q.size() == 0 || rdata !== exp_q[0]) begin
         errors++; $display("FAIL bp_hold got=%h first=%h", rdata, r0);
      end
      rready = 1'b1;
      for (int j = 0; j < 3; j++) begin
         checks++;
         if (rvalid !== 1'b1 || exp_q.size() == 0) begin
            errors++; $display("FAIL bp_rsp%0d rvalid=%b required=1", j, rvalid);
         end else begin
            e = exp_q.pop_front();
            if (rdata !== e) begin errors++; $display("FAIL bp_rsp%0d got=%h required=%h", j, rdata, e); end
         end
         if (j == 1) begin
            checks++;
            if (gnt !== 1'b1) begin errors++; $display("FAIL bp_gnt_return got=%b required=1", gnt); end
         end
         @(negedge clk);
      end
      checks++;
      if (rvalid !== 1'b0) begin errors++; $display("FAIL bp_extra rvalid=%b required=0", rvalid); end
      exp_q.delete();
      rready = 1'b0;
   endtask

   task automatic test_reset_mid_burst;
      int n;
      int seen = 0;
      logic [31:0] e;
      rready = 1'b0;
      issue(1'b0, 4'd1, 32'h0, 4'h0);
      issue(1'b0, 4'd2, 32'h0, 4'h0);
      req = 1'b0;
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      checks++;
      if (rvalid !== 1'b0) begin errors++; $display("FAIL midrst_rvalid got=%b required=0", rvalid); end
      @(negedge clk);
      rst = 1'b0; rready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         if (rvalid === 1'b1) seen++;
         @(negedge clk);
      end
      checks++;
      if (seen != 0) begin errors++; $display("FAIL midrst_stale got=%0d responses required=0", seen); end
      rready = 1'b0;
      issue(1'b0, 4'd1, 32'h0, 4'h0);
      req = 1'b0;
      rready = 1'b1; n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         if (rvalid === 1'b1) begin
            e = exp_q.pop_front(); checks++;
            if (rdata !== e) begin errors++; $display("FAIL midrst_retain got=%h required=%h", rdata, e); end
         end
         @(negedge clk); n++;
      end
      rready = 1'b0;
   endtask

   task automatic test_init;
      int n = 0;
      logic [31:0] e;
      z_rst = 1'b0;
      while (z_done !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      for (int a = 0; a < 16; a++) begin
         z_req = 1'b1; z_we = 1'b1; z_addr = 4'(a); z_wdata = 32'hA5A5_A5A5;
         n = 0;
         while (z_gnt !== 1'b1 && n < 20) begin @(negedge clk); n++; end
         @(negedge clk);
      end
      z_req = 1'b0;
      repeat (3) @(negedge clk);
      z_rst = 1'b1;
      @(negedge clk);
      checks += 4;
      if (z_gnt !== 1'b0)     begin errors++; $display("FAIL zrst_gnt got=%b required=0", z_gnt); end
      if (z_rvalid !== 1'b0)  begin errors++; $display("FAIL zrst_rvalid got=%b required=0", z_rvalid); end
      if (z_rdata !== 32'h0)  begin errors++; $display("FAIL zrst_rdata got=%h required=0", z_rdata); end
      if (z_done !== 1'b0)    begin errors++; $display("FAIL zrst_init_done got=%b required=0", z_done); end
      z_rst = 1'b0;
      for (int c = 0; c < 17; c++) begin
         checks++;
         if (z_gnt !== 1'b0 || z_done !== 1'b0) begin
            errors++; $display("FAIL init_wait cycle=%0d gnt=%b init_done=%b required=0/0", c, z_gnt, z_done);
         end
         @(negedge clk);
      end
      checks++;
      if (z_gnt !== 1'b1 || z_done !== 1'b1) begin
         errors++; $display("FAIL init_end gnt=%b init_done=%b required=1/1", z_gnt, z_done);
      end
      for (int a = 0; a < 16; a++) begin
         z_req = 1'b1; z_we = 1'b0; z_addr = 4'(a);
         n = 0;
         while (z_gnt !== 1'b1 && n < 20) begin @(negedge clk); n++; end
         exp_q.push_back(32'h0);
         @(negedge clk);
         z_req = 1'b0;
         checks++;
         if (z_rvalid !== 1'b1) begin
            errors++; $display("FAIL zero_rvalid addr=%0d got=%b required=1", a, z_rvalid);
            exp_q.delete();
         end else begin
            e = exp_q.pop_front();
            if (z_rdata !== e) begin errors++; $display("FAIL zero_rdata addr=%0d got=%h required=%h", a, z_rdata, e); end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_latency;
      int lat [4];
      int cnt [4];
      logic [31:0] got [4];
      for (int g = 0; g < 4; g++) begin lat[g] = 0; cnt[g] = 0; got[g] = '0; end
      s_req = 1'b1; s_we = 1'b1; s_addr = 4'd3; s_wdata = 32'h1234_5678;
      @(negedge clk);
      s_req = 1'b0;
      repeat (6) @(negedge clk);
      s_req = 1'b1; s_we = 1'b0; s_addr = 4'd3;
      for (int g = 0; g < 4; g++) begin
         checks++;
         if (s_gnt[g] !== 1'b1 || s_done[g] !== 1'b1) begin
            errors++; $display("FAIL lat%0d_gnt gnt=%b init_done=%b required=1/1", g + 1, s_gnt[g], s_done[g]);
         end
      end
      @(negedge clk);
      s_req = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         for (int g = 0; g < 4; g++) begin
            if (s_rvalid[g] === 1'b1) begin
               if (cnt[g] == 0) begin lat[g] = k; got[g] = s_rdata[g]; end
               cnt[g]++;
            end
         end
         @(negedge clk);
      end
      for (int g = 0; g < 4; g++) begin
         checks += 3;
         if (lat[g] != g + 1) begin errors++; $display("FAIL lat%0d_cycles got=%0d required=%0d", g + 1, lat[g], g + 1); end
         if (cnt[g] != 1)     begin errors++; $display("FAIL lat%0d_count got=%0d required=1", g + 1, cnt[g]); end
         if (got[g] !== 32'h1234_5678) begin errors++; $display("FAIL lat%0d_rdata got=%h required=12345678", g + 1, got[g]); end
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_fwd();
      test_wmask_zero();
      test_byte_mask();
`ifdef MEM_WR_ACK_EN
      test_wr_ack();
`else
      test_write_no_rsp();
`endif
      test_back_to_back();
      test_reset_mid_burst();
      test_init();
      test_latency();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
